lion_gate_driver: RTL

LION_GATE_DRIVER -- requirements
Module: lion_gate_driver

---
 rtl/lion_gate_if.sv | 21 ++
 rtl/lion_gate_driver.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/lion_gate_if.sv
// Command/gate bundle for lion_gate_driver.
// master: command source and gate observer. slave: the gate driver.
interface lion_gate_if;
  logic       cmd_valid;
  logic       cmd_dir;
  logic       cmd_ready;
  logic       g_one;
  logic       g_two;
  logic       busy;
  logic [3:0] expected_count;

  modport master (
    output cmd_valid, cmd_dir,
    input  cmd_ready, g_one, g_two, busy, expected_count
  );

  modport slave (
    input  cmd_valid, cmd_dir,
    output cmd_ready, g_one, g_two, busy, expected_count
  );
endinterface

// File: rtl/lion_gate_driver.sv
// lion_gate_driver: emulates a lion passing a two-beam light gate.
// Queued enter/exit commands are played out as four equal-length phases
// on g_one/g_two, stepping one beam at a time.
// Optional macro LION_GATE_SHADOW_COUNT_EN adds a wrapping 4-bit predicted
// lion count; without it expected_count is tied to zero.
//
// state | meaning
// IDLE  | no sequence running, gates 00
// P1    | first beam broken (enter: outer, exit: inner)
// P2    | both beams broken
// P3    | second beam only (enter: inner, exit: outer)
// GAP   | both beams clear before the next sequence may start
module lion_gate_driver #(
  parameter int PHASE_CYCLES = 4
) (
  input logic       clk,
  input logic       reset,
  lion_gate_if.slave bus
);

  typedef enum logic [2:0] {IDLE, P1, P2, P3, GAP} state_t;

  localparam logic [7:0] PHASE_LOAD = 8'(PHASE_CYCLES - 1);

  state_t     state, state_nxt;
  logic [7:0] timer, timer_nxt;
  logic       dir, dir_nxt;
  logic [1:0] gates, gates_nxt;

  logic [3:0] fifo_mem;
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] fifo_cnt;
  logic       push, pop;
  logic       fifo_nonempty;
  logic       phase_done;

  assign bus.cmd_ready = ~fifo_cnt[2];
  assign fifo_nonempty = (fifo_cnt != 3'd0);
  assign push          = bus.cmd_valid & bus.cmd_ready;
  assign phase_done    = (timer == 8'd0);
  assign bus.busy      = (state != IDLE) | fifo_nonempty;
  assign bus.g_one     = gates[1];
  assign bus.g_two     = gates[0];

  // Command FIFO; a pop and a push may land on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_mem <= 4'b0;
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      fifo_cnt <= 3'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= bus.cmd_dir;
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      fifo_cnt <= fifo_cnt + 3'(push) - 3'(pop);
    end
  end

  // FSM state, phase down-counter, latched direction and registered gates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      timer <= 8'd0;
      dir   <= 1'b0;
      gates <= 2'b00;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      dir   <= dir_nxt;
      gates <= gates_nxt;
    end
  end

  // Next-state: each phase runs until the down-counter reaches zero; GAP
  // chains straight into the next queued command to avoid an IDLE bubble.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    dir_nxt   = dir;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_nonempty) begin
          pop       = 1'b1;
          dir_nxt   = fifo_mem[rd_ptr];
          state_nxt = P1;
          timer_nxt = PHASE_LOAD;
        end
      end
      P1, P2, P3: begin
        if (phase_done) begin
          timer_nxt = PHASE_LOAD;
          case (state)
            P1:      state_nxt = P2;
            P2:      state_nxt = P3;
            default: state_nxt = GAP;
          endcase
        end else begin
          timer_nxt = timer - 8'd1;
        end
      end
      GAP: begin
        if (!phase_done) begin
          timer_nxt = timer - 8'd1;
        end else if (fifo_nonempty) begin
          pop       = 1'b1;
          dir_nxt   = fifo_mem[rd_ptr];
          state_nxt = P1;
          timer_nxt = PHASE_LOAD;
        end else begin
          state_nxt = IDLE;
          timer_nxt = 8'd0;
        end
      end
      default: begin
        state_nxt = IDLE;
        timer_nxt = 8'd0;
      end
    endcase
  end

  // Gate pattern for the upcoming state, so the outputs are registered and
  // change in step with the state (one beam toggles per transition).
  always_comb begin
    gates_nxt = 2'b00;
    case (state_nxt)
      P1:      gates_nxt = dir_nxt ? 2'b10 : 2'b01;
      P2:      gates_nxt = 2'b11;
      P3:      gates_nxt = dir_nxt ? 2'b01 : 2'b10;
      default: gates_nxt = 2'b00;
    endcase
  end

`ifdef LION_GATE_SHADOW_COUNT_EN
  logic [3:0] shadow_count;

  // Predicted count moves when the lion has fully cleared the inner/outer beam.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_count <= 4'd0;
    end else if ((state == P3) && (state_nxt == GAP)) begin
      shadow_count <= dir ? shadow_count + 4'd1 : shadow_count - 4'd1;
    end
  end

  assign bus.expected_count = shadow_count;
`else
  assign bus.expected_count = 4'd0;
`endif

endmodule
